// File: rtl/dcim_pkg.sv
// Shared types and helpers for the DCIM MAC array.
// Defines the load/compute state enum, mode encodings and result width helper.
package dcim_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_MAC = 1'b1;

    // Widest possible full-depth dot product: product bits plus one
    // carry bit per doubling of the accumulation depth.
    function automatic int acc_width(input int dw, input int aw);
        return 2 * dw + aw;
    endfunction

endpackage

// File: rtl/dcim_lane.sv
// One DCIM lane: a weight bank with synchronous read and a product/accumulate register.
// Ports: clk, rst; we/wr_addr/wdata write port; rd_en/rd_addr read port;
// act (stage-1 activation); acc_en/acc_load/clr accumulator control; acc result.
module dcim_lane
    import dcim_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_COUNT = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int SIGNED     = 0,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] act,
    input  logic                  acc_en,
    input  logic                  acc_load,
    input  logic                  clr,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] mem [ADDR_COUNT];
    logic [DATA_WIDTH-1:0] weight;
    logic [PW-1:0]         w_ext;
    logic [PW-1:0]         a_ext;
    logic [PW-1:0]         prod;
    logic [ACC_WIDTH-1:0]  prod_ext;

    // Weight storage carries no reset; contents are only meaningful
    // after a completed load phase.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wdata;
        end
        if (rd_en) begin
            weight <= mem[rd_addr];
        end
    end

    // Operands are widened to the full product width first so the
    // truncated multiply yields the exact product in either signedness.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_ext    = {{DATA_WIDTH{weight[DATA_WIDTH-1]}}, weight};
            assign a_ext    = {{DATA_WIDTH{act[DATA_WIDTH-1]}}, act};
            assign prod     = w_ext * a_ext;
            assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
        end else begin : g_unsigned
            assign w_ext    = {{DATA_WIDTH{1'b0}}, weight};
            assign a_ext    = {{DATA_WIDTH{1'b0}}, act};
            assign prod     = w_ext * a_ext;
            assign prod_ext = {{(ACC_WIDTH-PW){1'b0}}, prod};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc_load ? prod_ext : acc + prod_ext;
        end
    end

endmodule

// File: rtl/dcim_mac_array.sv
// Multi-lane DCIM weight store with streaming MUL / full-depth MAC compute.
// Ports: clk, rst, pe_ce; init_enable/weight_in/init_done load phase; mode;
// in_valid/in_ready/data_in activations; out_valid/out_ready/data_out results.
module dcim_mac_array
    import dcim_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_COUNT = 32,
    parameter int ADDR_WIDTH = $clog2(ADDR_COUNT),
    parameter int LANES      = 4,
    parameter int SIGNED     = 0,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pe_ce,
    input  logic                        init_enable,
    input  logic [LANES*DATA_WIDTH-1:0] weight_in,
    input  logic                        mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic [LANES*ACC_WIDTH-1:0]  data_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_COUNT - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  mode_q;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_act;
    logic                  s1_first;
    logic                  s1_last;
    logic                  s1_mode;

    logic                  stall;
    logic                  accept;
    logic                  load_start;
    logic                  load_wr;
    logic                  cur_mode;
    logic                  acc_en;
    logic                  acc_load;

    assign stall      = !pe_ce || (out_valid && !out_ready);
    assign in_ready   = !rst && (state == READY) && !init_enable && !stall;
    assign accept     = in_valid && in_ready;

    // A reload flushes any pending result, so it only waits on pe_ce.
    assign load_start = pe_ce && init_enable && (state != LOAD);
    assign load_wr    = pe_ce && init_enable && (state == LOAD);

    // Mode is taken live for word 0 and held from then on in the pass.
    assign cur_mode   = (rd_addr == '0) ? mode : mode_q;

    assign acc_en     = s1_valid && !stall;
    assign acc_load   = s1_first || (s1_mode == MODE_MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            wr_addr   <= '0;
            rd_addr   <= '0;
            mode_q    <= MODE_MUL;
            s1_valid  <= 1'b0;
            s1_act    <= '0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_mode   <= MODE_MUL;
            out_valid <= 1'b0;
            init_done <= 1'b0;
        end else if (load_start) begin
            state     <= LOAD;
            wr_addr   <= '0;
            rd_addr   <= '0;
            init_done <= 1'b0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == LOAD) begin
            if (pe_ce) begin
                if (init_enable) begin
                    if (wr_addr == LAST_ADDR) begin
                        state     <= READY;
                        wr_addr   <= '0;
                        init_done <= 1'b1;
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end else begin
                    state <= EMPTY;
                end
            end
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_act   <= data_in;
                s1_first <= (rd_addr == '0);
                s1_last  <= (rd_addr == LAST_ADDR);
                s1_mode  <= cur_mode;
                mode_q   <= cur_mode;
                rd_addr  <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
            end
            out_valid <= s1_valid &&
                         ((s1_mode == MODE_MUL) || s1_last);
        end
    end

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            logic [ACC_WIDTH-1:0] lane_acc;

            dcim_lane #(
                .DATA_WIDTH(DATA_WIDTH),
                .ADDR_COUNT(ADDR_COUNT),
                .ADDR_WIDTH(ADDR_WIDTH),
                .SIGNED    (SIGNED),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .we      (load_wr),
                .wr_addr (wr_addr),
                .wdata   (weight_in[i*DATA_WIDTH +: DATA_WIDTH]),
                .rd_en   (accept),
                .rd_addr (rd_addr),
                .act     (s1_act),
                .acc_en  (acc_en),
                .acc_load(acc_load),
                .clr     (load_start),
                .acc     (lane_acc)
            );

            assign data_out[i*ACC_WIDTH +: ACC_WIDTH] = lane_acc;
        end
    endgenerate

endmodule

// File: tb/tb_dcim_mac_array.sv
// Directed self-checking bench for dcim_mac_array.
// Drives load, MUL/MAC streams, backpressure, clock-enable, reload and reset cases.
module tb_dcim_mac_array;

    localparam int DW  = 16;
    localparam int NW  = 32;
    localparam int NL  = 4;
    localparam int ACC = 37;

    logic clk = 1'b0;
    logic rst;
    logic pe_ce;
    logic mode;

    logic              init_enable;
    logic [NL*DW-1:0]  weight_in;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     data_in;
    logic [NL*ACC-1:0] data_out;
    logic              out_valid;
    logic              out_ready;
    logic              init_done;

    logic              init_enable_s;
    logic [NL*DW-1:0]  weight_in_s;
    logic              in_valid_s;
    logic              in_ready_s;
    logic [DW-1:0]     data_in_s;
    logic [NL*ACC-1:0] data_out_s;
    logic              out_valid_s;
    logic              out_ready_s;
    logic              init_done_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcim_mac_array #(.SIGNED(0)) u0 (
        .clk        (clk),
        .rst        (rst),
        .pe_ce      (pe_ce),
        .init_enable(init_enable),
        .weight_in  (weight_in),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .init_done  (init_done)
    );

    dcim_mac_array #(.SIGNED(1)) u1 (
        .clk        (clk),
        .rst        (rst),
        .pe_ce      (pe_ce),
        .init_enable(init_enable_s),
        .weight_in  (weight_in_s),
        .mode       (mode),
        .in_valid   (in_valid_s),
        .in_ready   (in_ready_s),
        .data_in    (data_in_s),
        .data_out   (data_out_s),
        .out_valid  (out_valid_s),
        .out_ready  (out_ready_s),
        .init_done  (init_done_s)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lane(input int l);
        return 64'(data_out[l*ACC +: ACC]);
    endfunction

    task automatic load(input int nw, input int base);
        @(negedge clk);
        init_enable = 1'b1;
        weight_in   = '0;
        @(negedge clk);
        for (int k = 0; k < nw; k++) begin
            weight_in = {NL{16'(base + k)}};
            @(negedge clk);
        end
        init_enable = 1'b0;
        weight_in   = '0;
        @(negedge clk);
    endtask

    // Streams n_in activations and checks every consumed result against
    // weight(k) = k+1 in all lanes.
    task automatic stream(input logic m, input logic [15:0] act,
                          input int n_in, input int n_out,
                          input int hold_at, input int hold_len,
                          input int ce_at, input int ce_len,
                          input bit chk_lat);
        int acc_cnt  = 0;
        int out_cnt  = 0;
        int cyc      = 0;
        int last_acc = 0;
        int ref_cyc;
        int q[$];
        logic [NL*ACC-1:0] held = '0;
        bit held_ok = 0;
        logic [63:0] e;
        mode    = m;
        data_in = act;
        while ((acc_cnt < n_in || out_cnt < n_out) && cyc < 400) begin
            in_valid  = (acc_cnt < n_in);
            pe_ce     = !(cyc >= ce_at && cyc < ce_at + ce_len);
            out_ready = pe_ce && !(cyc >= hold_at && cyc < hold_at + hold_len);
            #1;
            if (out_valid && out_ready) begin
                if (m == 1'b1) e = 64'(act) * 64'd528;
                else           e = 64'(act) * 64'((out_cnt % NW) + 1);
                for (int l = 0; l < NL; l++) check("stream_data", lane(l), e);
                if (chk_lat) begin
                    if (m == 1'b1)        ref_cyc = last_acc;
                    else if (q.size() > 0) ref_cyc = q.pop_front();
                    else                  ref_cyc = -100;
                    check("latency", 64'(cyc - ref_cyc), 64'd2);
                end
                out_cnt++;
            end
            if (out_valid && !out_ready && pe_ce) begin
                check("hold_in_ready", 64'(in_ready), 64'd0);
                if (held_ok) check("hold_stable", 64'(data_out != held), 64'd0);
                held    = data_out;
                held_ok = 1;
            end else begin
                held_ok = 0;
            end
            if (in_valid && in_ready) begin
                q.push_back(cyc);
                last_acc = cyc;
                acc_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        pe_ce     = 1'b1;
        out_ready = 1'b1;
        check("stream_timeout", 64'(cyc < 400), 64'd1);
        check("stream_count", 64'(out_cnt), 64'(n_out));
    endtask

    initial begin
        int wait_cyc;
        rst           = 1'b1;
        pe_ce         = 1'b1;
        mode          = 1'b0;
        init_enable   = 1'b0;
        weight_in     = '0;
        in_valid      = 1'b0;
        data_in       = '0;
        out_ready     = 1'b1;
        init_enable_s = 1'b0;
        weight_in_s   = '0;
        in_valid_s    = 1'b0;
        data_in_s     = '0;
        out_ready_s   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        in_valid = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_data_out", 64'(data_out != '0), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);

        // Test 1: full load, MUL by 3
        load(NW, 1);
        check("load_init_done", 64'(init_done), 64'd1);
        stream(1'b0, 16'd3, NW, NW, 1000, 0, 1000, 0, 1'b1);

        // Test 2: MAC by 1, two passes
        stream(1'b1, 16'd1, NW, 1, 1000, 0, 1000, 0, 1'b1);
        stream(1'b1, 16'd1, NW, 1, 1000, 0, 1000, 0, 1'b1);
        @(negedge clk);
        check("mac_idle_out_valid", 64'(out_valid), 64'd0);

        // Test 4: backpressure and clock-enable gap, same sequence as test 1
        stream(1'b0, 16'd3, NW, NW, 6, 5, 15, 4, 1'b0);

        // Test 3: signed lane product
        @(negedge clk);
        init_enable_s = 1'b1;
        @(negedge clk);
        weight_in_s = {16'd5, 16'd5, 16'd5, 16'hFFFF};
        repeat (NW) @(negedge clk);
        init_enable_s = 1'b0;
        @(negedge clk);
        check("s_init_done", 64'(init_done_s), 64'd1);
        mode       = 1'b0;
        data_in_s  = 16'd2;
        in_valid_s = 1'b1;
        @(negedge clk);
        in_valid_s = 1'b0;
        wait_cyc = 0;
        while (!out_valid_s && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("s_timeout", 64'(wait_cyc < 10), 64'd1);
        check("s_lane0", 64'(data_out_s[0 +: ACC]), 64'h1F_FFFF_FFFE);
        check("s_lane1", 64'(data_out_s[ACC +: ACC]), 64'd10);

        // Test 5: aborted load, then full reload
        load(10, 100);
        check("partial_init_done", 64'(init_done), 64'd0);
        in_valid = 1'b1;
        #1;
        check("partial_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        load(NW, 1);
        check("reload_init_done", 64'(init_done), 64'd1);
        stream(1'b0, 16'd2, NW, NW, 1000, 0, 1000, 0, 1'b1);

        // Test 6: reset in the middle of a MAC pass
        stream(1'b1, 16'd1, 17, 0, 1000, 0, 1000, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_init_done", 64'(init_done), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_data_out", 64'(data_out != '0), 64'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("mid_rst_no_result", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
